addfloat_reduce: RTL

- Parametrised successor to the single-operand float-add-constant run block.
- Accepts a vector of CH IEEE-754 single-precision operands and adds the first N of them serially onto a BIAS constant. Mode selects add or subtract.
- Uses one instance of the team's pipelined AddFloat IP core: ports aclk, aclken, A_AXI_A, S_AXIS_B, S_AXIS_RESULT; fixed latency ADD_LAT.
- Sits behind the same run req/busy/return call protocol used by the generated method blocks.

---
 rtl/addfloat_reduce_if.sv | 24 ++
 rtl/addfloat_reduce.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/addfloat_reduce_if.sv
// rtl/addfloat_reduce_if.sv - run call bus (req/busy/return) for addfloat_reduce
interface addfloat_reduce_if #(
    parameter int CH = 4
);
    localparam int CNT_W = $clog2(CH + 1);

    logic                i_run_req;
    logic                i_run_mode;
    logic [CNT_W-1:0]    i_run_count;
    logic [32*CH-1:0]    i_run_input;
    logic                o_run_busy;
    logic                o_run_done;
    logic [31:0]         o_run_return;

    modport master (
        output i_run_req, i_run_mode, i_run_count, i_run_input,
        input  o_run_busy, o_run_done, o_run_return
    );

    modport slave (
        input  i_run_req, i_run_mode, i_run_count, i_run_input,
        output o_run_busy, o_run_done, o_run_return
    );
endinterface

// File: rtl/addfloat_reduce.sv
// rtl/addfloat_reduce.sv - serially adds/subtracts the first N of CH float operands onto BIAS
module addfloat_reduce #(
    parameter int          CH      = 4,
    parameter int          ADD_LAT = 5,
    parameter logic [31:0] BIAS    = 32'h3fa66666
) (
    input logic              clock,
    input logic              reset,
    input logic              ce,
    addfloat_reduce_if.slave run
);
    localparam int CNT_W  = $clog2(CH + 1);
    localparam int WAIT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   idx;
    logic [CNT_W-1:0]   n_op;
    logic               mode;
    logic [32*CH-1:0]   ops;
    logic [31:0]        acc;
    logic [31:0]        port_a;
    logic [31:0]        port_b;
    logic [WAIT_W-1:0]  cnt;
    logic               busy;
    logic               done;
    logic [31:0]        ret;
    logic [31:0]        x_cur;
    logic [31:0]        ip_result;

    always_comb begin
        x_cur = ops[31:0];
        for (int i = 1; i < CH; i++) begin
            if (idx == CNT_W'(i)) x_cur = ops[32*i +: 32];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= S_IDLE;
            idx    <= '0;
            n_op   <= '0;
            mode   <= 1'b0;
            ops    <= '0;
            acc    <= '0;
            port_a <= '0;
            port_b <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            ret    <= '0;
        end else if (ce) begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (run.i_run_req) begin
                        ops   <= run.i_run_input;
                        mode  <= run.i_run_mode;
                        n_op  <= (run.i_run_count > CNT_W'(CH)) ? CNT_W'(CH) : run.i_run_count;
                        acc   <= BIAS;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= (run.i_run_count == '0) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // flipping the operand sign turns the adder into a subtractor
                    port_a <= acc;
                    port_b <= {x_cur[31] ^ mode, x_cur[30:0]};
                    cnt    <= '0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt + WAIT_W'(1);
                    if (cnt == WAIT_W'(ADD_LAT - 1)) state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    acc   <= ip_result;
                    idx   <= idx + CNT_W'(1);
                    state <= (idx == n_op - CNT_W'(1)) ? S_DONE : S_ISSUE;
                end
                S_DONE: begin
                    ret   <= acc;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign run.o_run_busy   = busy;
    assign run.o_run_done   = done;
    assign run.o_run_return = ret;

    add_float #(.LAT(ADD_LAT)) u_add (
        .aclk          (clock),
        .aclken        (ce),
        .A_AXI_A       (port_a),
        .S_AXIS_B      (port_b),
        .S_AXIS_RESULT (ip_result)
    );
endmodule

// Pipelined single-precision adder, round-to-nearest-even, result LAT enabled cycles after the inputs.
module add_float #(
    parameter int LAT = 5
) (
    input  logic        aclk,
    input  logic        aclken,
    input  logic [31:0] A_AXI_A,
    input  logic [31:0] S_AXIS_B,
    output logic [31:0] S_AXIS_RESULT
);
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y;
        logic [7:0]  ex, ey;
        logic [26:0] mx, my, ym;
        logic [27:0] s;
        logic [9:0]  e, d, sh;
        logic [4:0]  lz;
        logic        found, up;
        logic [24:0] m;
        if (a[30:0] >= b[30:0]) begin
            x = a; y = b;
        end else begin
            x = b; y = a;
        end
        if (x[30:23] == 8'hff) begin
            if (x[22:0] != 23'd0 || (y[30:0] == x[30:0] && x[31] != y[31])) return 32'h7fc00000;
            return x;
        end
        ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
        mx = {x[30:23] != 8'd0, x[22:0], 3'b000};
        my = {y[30:23] != 8'd0, y[22:0], 3'b000};
        d  = {2'b00, ex} - {2'b00, ey};
        // align the smaller operand; bits shifted out collapse into the sticky bit
        if (d > 10'd26) begin
            ym = {26'd0, |my};
        end else begin
            ym    = my >> d[4:0];
            ym[0] = ym[0] | (|(my & ~(27'h7ffffff << d[4:0])));
        end
        s = (x[31] == y[31]) ? ({1'b0, mx} + {1'b0, ym}) : ({1'b0, mx} - {1'b0, ym});
        if (s == 28'd0) return {x[31] & y[31], 31'd0};
        e = {2'b00, ex};
        if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e = e + 10'd1;
        end else begin
            lz    = 5'd0;
            found = 1'b0;
            for (int i = 26; i >= 0; i--) begin
                if (s[i]) found = 1'b1;
                else if (!found) lz = lz + 5'd1;
            end
            sh = ({5'd0, lz} < e - 10'd1) ? {5'd0, lz} : e - 10'd1;
            s  = s << sh;
            e  = e - sh;
        end
        up = s[2] & (s[1] | s[0] | s[3]);
        m  = {1'b0, s[26:3]} + {24'd0, up};
        if (m[24]) begin
            m = m >> 1;
            e = e + 10'd1;
        end
        if (e >= 10'd255) return {x[31], 8'hff, 23'd0};
        return {x[31], m[23] ? e[7:0] : 8'd0, m[22:0]};
    endfunction

    logic [31:0] pipe [LAT];

    always_ff @(posedge aclk) begin
        if (aclken) begin
            pipe[0] <= fadd(A_AXI_A, S_AXIS_B);
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign S_AXIS_RESULT = pipe[LAT-1];
endmodule
